// File: rtl/idli_alu_m.sv
// -----------------------------------------------------------------------------
// idli_pkg / idli_alu_m
//
// Bit-serial execute stage. A 16-bit operation is processed as four 4-bit
// slices over four consecutive cycles, least-significant slice first. Carry and
// zero state ride across slices. The final Z/C flags are registered for the
// branch logic.
//
// Optional feature macro: IDLI_ALU_SHIFT_EN
//   defined   -> ops 6/7 execute SRL/SLL using the neighbour bits
//   undefined -> ops 6/7 are illegal; i_alu_lhs_next/i_alu_lhs_prev are ignored
//
// Ports
//   i_alu_gck, i_alu_rst_n        clock / async active-low reset
//   i_alu_start                   start request (accepted only when idle)
//   i_alu_op, i_alu_wr, i_alu_dst operation, write-back enable, destination
//   i_alu_lhs_data/rhs_data       operand slices from the register file
//   i_alu_lhs_next/lhs_prev       LHS bits just above / below the slice
//   o_alu_busy                    running after the accept cycle
//   o_alu_dst/_en/_data           register-file write port for this slice
//   o_alu_done                    last slice cycle
//   o_alu_illegal                 accept of an unsupported op
//   o_alu_flag_z/_c               registered zero / carry flags
// -----------------------------------------------------------------------------
package idli_pkg;
  typedef logic [15:0] data_t;
  typedef logic [3:0]  slice_t;
  typedef logic [3:0]  reg_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ANDN = 3'd5,
    OP_SRL  = 3'd6,
    OP_SLL  = 3'd7
  } alu_op_e;
endpackage

module idli_alu_m
  import idli_pkg::*;
(
  input  logic   i_alu_gck,
  input  logic   i_alu_rst_n,
  input  logic   i_alu_start,
  input  logic   [2:0] i_alu_op,
  input  logic   i_alu_wr,
  input  reg_t   i_alu_dst,
  input  slice_t i_alu_lhs_data,
  input  slice_t i_alu_rhs_data,
  input  logic   i_alu_lhs_next,
  input  logic   i_alu_lhs_prev,
  output logic   o_alu_busy,
  output reg_t   o_alu_dst,
  output logic   o_alu_dst_en,
  output slice_t o_alu_dst_data,
  output logic   o_alu_done,
  output logic   o_alu_illegal,
  output logic   o_alu_flag_z,
  output logic   o_alu_flag_c
);

`ifdef IDLI_ALU_SHIFT_EN
  localparam logic SHIFT_EN = 1'b1;
`else
  localparam logic SHIFT_EN = 1'b0;
  logic unused_shift_bits;
  assign unused_shift_bits = i_alu_lhs_next ^ i_alu_lhs_prev;
`endif

  // State
  logic    run_q, run_d;
  logic    [1:0] cnt_q, cnt_d;
  logic    carry_q, carry_d;
  logic    zacc_q, zacc_d;
  alu_op_e op_q, op_d;
  logic    wr_q, wr_d;
  reg_t    dst_q, dst_d;
  logic    ill_q, ill_d;
  logic    flag_z_q, flag_z_d;
  logic    flag_c_q, flag_c_d;

  // Per-cycle decode and datapath
  logic    accept, active, slice_first, slice_last;
  alu_op_e op_cur;
  logic    wr_cur, ill_cur, ill_in;
  reg_t    dst_cur;
  logic    cin, cout, shift_next, shift_prev, res_zero;
  slice_t  rhs_eff, res;
  logic    [4:0] sum;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    // Gating with reset keeps the write port quiet while reset is asserted.
    accept      = i_alu_start & ~run_q & i_alu_rst_n;
    active      = run_q | accept;
    slice_first = (cnt_q == 2'd0);
    slice_last  = (cnt_q == 2'd3);

    // Ops 6/7 only exist when the shift feature is built in.
    ill_in  = ~SHIFT_EN & i_alu_op[2] & i_alu_op[1];

    // The accept cycle decodes straight from the inputs; later slices use
    // the values latched on accept.
    op_cur  = run_q ? op_q  : alu_op_e'(i_alu_op);
    wr_cur  = run_q ? wr_q  : i_alu_wr;
    dst_cur = run_q ? dst_q : i_alu_dst;
    ill_cur = run_q ? ill_q : ill_in;

`ifdef IDLI_ALU_SHIFT_EN
    // Bits shifted in from beyond the 16-bit word are zero.
    shift_next = slice_last  ? 1'b0 : i_alu_lhs_next;
    shift_prev = slice_first ? 1'b0 : i_alu_lhs_prev;
`else
    shift_next = 1'b0;
    shift_prev = 1'b0;
`endif

    // SUB is lhs + ~rhs + 1, with the +1 injected as slice 0 carry-in.
    cin     = slice_first ? (op_cur == OP_SUB) : carry_q;
    rhs_eff = (op_cur == OP_SUB) ? ~i_alu_rhs_data : i_alu_rhs_data;
    sum     = {1'b0, i_alu_lhs_data} + {1'b0, rhs_eff} + {4'b0000, cin};
    cout    = sum[4];

    res = '0;
    case (op_cur)
      OP_ADD, OP_SUB: res = sum[3:0];
      OP_AND:         res = i_alu_lhs_data & i_alu_rhs_data;
      OP_OR:          res = i_alu_lhs_data | i_alu_rhs_data;
      OP_XOR:         res = i_alu_lhs_data ^ i_alu_rhs_data;
      OP_ANDN:        res = i_alu_lhs_data & ~i_alu_rhs_data;
      OP_SRL:         res = {shift_next, i_alu_lhs_data[3:1]};
      OP_SLL:         res = {i_alu_lhs_data[2:0], shift_prev};
      default:        res = '0;
    endcase
    res_zero = (res == 4'd0);

    // Next-state defaults: hold.
    run_d    = run_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    op_d     = op_q;
    wr_d     = wr_q;
    dst_d    = dst_q;
    ill_d    = ill_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;

    if (active) begin
      cnt_d   = cnt_q + 2'd1;   // wraps 3 -> 0 at the end of the op
      carry_d = cout;
      zacc_d  = (slice_first | zacc_q) & res_zero;
    end

    if (accept) begin
      run_d = 1'b1;
      op_d  = alu_op_e'(i_alu_op);
      wr_d  = i_alu_wr;
      dst_d = i_alu_dst;
      ill_d = ill_in;
    end else if (run_q && slice_last) begin
      run_d = 1'b0;
      // An illegal op leaves the flags alone.
      if (!ill_q) begin
        flag_z_d = zacc_d;
        flag_c_d = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? cout : 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same edge, regardless of statement order.
  // NOTE: every flop here is control/pipeline state (no storage arrays), so
  // all of it is reset to give a defined idle state after an abort.
  always_ff @(posedge i_alu_gck or negedge i_alu_rst_n) begin
    if (!i_alu_rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      op_q     <= OP_ADD;
      wr_q     <= 1'b0;
      dst_q    <= '0;
      ill_q    <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      op_q     <= op_d;
      wr_q     <= wr_d;
      dst_q    <= dst_d;
      ill_q    <= ill_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign o_alu_busy     = run_q;
  assign o_alu_dst      = active ? dst_cur : '0;
  assign o_alu_dst_en   = active & wr_cur & ~ill_cur;
  assign o_alu_dst_data = active ? res : '0;
  assign o_alu_done     = run_q & slice_last;
  assign o_alu_illegal  = accept & ill_in;
  assign o_alu_flag_z   = flag_z_q;
  assign o_alu_flag_c   = flag_c_q;

endmodule

// File: tb/tb_idli_alu_m.sv
// -----------------------------------------------------------------------------
// tb_idli_alu_m
//
// Self-checking bench for idli_alu_m. Each operation is modelled as a whole
// 16-bit computation; the expected write-port slices are cut from that word and
// the expected flags are derived from it. Directed cases cover the corner
// behaviour, followed by a randomized run with occasional idle gaps.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idli_alu_m;

`ifdef IDLI_ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] i_op;
  logic       i_wr;
  logic [3:0] i_dst;
  logic [3:0] lhs, rhs;
  logic       nxt, prv;
  logic       busy, dst_en, done, illegal, flag_z, flag_c;
  logic [3:0] o_dst, o_data;

  int total = 0;
  int bad   = 0;

  // Flags the model expects the DUT to be holding.
  logic exp_z = 1'b0;
  logic exp_c = 1'b0;

  idli_alu_m dut (
    .i_alu_gck      (clk),
    .i_alu_rst_n    (rst_n),
    .i_alu_start    (start),
    .i_alu_op       (i_op),
    .i_alu_wr       (i_wr),
    .i_alu_dst      (i_dst),
    .i_alu_lhs_data (lhs),
    .i_alu_rhs_data (rhs),
    .i_alu_lhs_next (nxt),
    .i_alu_lhs_prev (prv),
    .o_alu_busy     (busy),
    .o_alu_dst      (o_dst),
    .o_alu_dst_en   (dst_en),
    .o_alu_dst_data (o_data),
    .o_alu_done     (done),
    .o_alu_illegal  (illegal),
    .o_alu_flag_z   (flag_z),
    .o_alu_flag_c   (flag_c)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit op_legal(input logic [2:0] op);
    return (op < 3'd6) || SHIFT_EN;
  endfunction

  // Whole-word reference: result and carry-out of bit 15.
  task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic c);
    logic [16:0] w;
    c = 1'b0;
    r = 16'h0;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b};          r = w[15:0]; c = w[16]; end
      3'd1: begin w = {1'b0, a} + {1'b0, ~b} + 17'd1; r = w[15:0]; c = w[16]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a & ~b;
      3'd6: r = a >> 1;
      default: r = a << 1;
    endcase
  endtask

  task automatic check_flags(input string where);
    check({where, ".flag_z"}, {31'd0, flag_z}, {31'd0, exp_z});
    check({where, ".flag_c"}, {31'd0, flag_c}, {31'd0, exp_c});
  endtask

  // Drives one four-slice operation starting at the next negedge and checks
  // every slice. poke=1 raises start again in T+2, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic wr, input logic [3:0] dst, input bit poke);
    logic [15:0] r;
    logic        c;
    bit          legal;
    logic [16:0] a_up;
    logic [16:0] a_dn;
    model(op, a, b, r, c);
    legal = op_legal(op);
    a_up  = {1'b0, a};
    a_dn  = {a, 1'b0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = (k == 0) || (poke && k == 2);
      if (k == 0) begin
        i_op = op; i_wr = wr; i_dst = dst;
      end else begin
        i_op = 3'($urandom); i_wr = 1'($urandom); i_dst = 4'($urandom);
      end
      lhs = a[4*k +: 4];
      rhs = b[4*k +: 4];
      // Neighbour bits beyond the word are driven with junk; the DUT must
      // force them to zero.
      nxt = (k < 3) ? a_up[4*k + 4] : 1'($urandom);
      prv = (k > 0) ? a_dn[4*k]     : 1'($urandom);
      #2;
      check_flags("held");
      check("dst_en",  {31'd0, dst_en},  {31'd0, (wr && legal)});
      check("dst",     {28'd0, o_dst},   {28'd0, dst});
      if (legal) check("data", {28'd0, o_data}, {28'd0, r[4*k +: 4]});
      check("busy",    {31'd0, busy},    {31'd0, (k > 0)});
      check("done",    {31'd0, done},    {31'd0, (k == 3)});
      check("illegal", {31'd0, illegal}, {31'd0, (k == 0 && !legal)});
    end
    start = 1'b0;
    if (legal) begin
      exp_z = (r == 16'h0);
      exp_c = (op < 3'd2) ? c : 1'b0;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0;
    i_op = 3'($urandom); i_wr = 1'($urandom); i_dst = 4'($urandom);
    lhs = 4'($urandom); rhs = 4'($urandom);
    #2;
    check("idle.busy",   {31'd0, busy},   32'd0);
    check("idle.dst_en", {31'd0, dst_en}, 32'd0);
    check("idle.done",   {31'd0, done},   32'd0);
    check_flags("idle");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    i_op = '0; i_wr = 1'b0; i_dst = '0;
    lhs = '0; rhs = '0; nxt = 1'b0; prv = 1'b0;
    #12;
    check("rst.busy",    {31'd0, busy},    32'd0);
    check("rst.dst_en",  {31'd0, dst_en},  32'd0);
    check("rst.done",    {31'd0, done},    32'd0);
    check("rst.illegal", {31'd0, illegal}, 32'd0);
    check("rst.dst",     {28'd0, o_dst},   32'd0);
    check("rst.data",    {28'd0, o_data},  32'd0);
    check_flags("rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // Carry ripples into slice 2.
    run_op(3'd0, 16'h00FF, 16'h0001, 1'b1, 4'd3, 1'b0);
    idle_cycle();
    // Compare: equal operands, then a borrow.
    run_op(3'd1, 16'h1234, 16'h1234, 1'b0, 4'd5, 1'b0);
    idle_cycle();
    // Shifts with set end bits; illegal (flags hold) without the feature.
    run_op(3'd6, 16'h8001, 16'h0000, 1'b1, 4'd2, 1'b0);
    run_op(3'd7, 16'h8001, 16'h0000, 1'b1, 4'd2, 1'b0);
    idle_cycle();
    run_op(3'd1, 16'h0000, 16'h0001, 1'b0, 4'd5, 1'b0);
    idle_cycle();
    // Start in T+2 is ignored; back-to-back accept at T+4.
    run_op(3'd0, 16'hFFFF, 16'h0001, 1'b1, 4'd7, 1'b1);
    run_op(3'd4, 16'hFFFF, 16'h0F0F, 1'b1, 4'd9, 1'b0);
    idle_cycle();

    // Reset in T+1 of an ADD, with both flags set beforehand.
    run_op(3'd1, 16'h1234, 16'h1234, 1'b0, 4'd1, 1'b0);
    @(negedge clk);
    start = 1'b1; i_op = 3'd0; i_wr = 1'b1; i_dst = 4'd4;
    lhs = 4'h1; rhs = 4'h2;
    #2;
    check("pre_abort.dst_en", {31'd0, dst_en}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("pre_abort.busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_z = 1'b0; exp_c = 1'b0;
    check("abort.dst_en", {31'd0, dst_en}, 32'd0);
    check("abort.busy",   {31'd0, busy},   32'd0);
    check_flags("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd2, 16'hFFFF, 16'h00F0, 1'b1, 4'd6, 1'b0);
    // Destination ZR still updates flags.
    run_op(3'd1, 16'h0042, 16'h0042, 1'b1, 4'd0, 1'b0);
    idle_cycle();

    for (int n = 0; n < 80; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 16'h0;
        default: b = 16'($urandom);
      endcase
      run_op(3'($urandom_range(0, 7)), a, b, 1'($urandom), 4'($urandom), 1'($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
